// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op and FSM state encodings plus a width helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_SLT = 3'b011,
    OP_SRL = 3'b100,
    OP_SRA = 3'b101,
    OP_SLL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } alu_state_e;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: moves at most SHIFT_STEP bit positions per cycle until the
// loaded amount is exhausted; done/result show the value produced by the final step.
module alu_shift_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  alu_op_e                         op,
  input  logic [WIDTH-1:0]                data,
  input  logic [shamt_width(WIDTH)-1:0]   amount,
  output logic                            done,
  output logic [WIDTH-1:0]                result
);

  localparam int SW = shamt_width(WIDTH);
  // One extra bit so a SHIFT_STEP equal to WIDTH is still representable.
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             fill_q, fill_d;
  logic             left_q, left_d;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    fill_d = fill_q;
    left_d = left_q;

    step = (rem_q > STEP_C) ? STEP_C : rem_q;
    if (left_q) begin
      shifted = data_q << step;
    end else begin
      shifted = (data_q >> step) | (fill_q ? ~({WIDTH{1'b1}} >> step) : '0);
    end

    done   = (rem_q != '0) && (rem_q <= STEP_C);
    result = shifted;

    if (start) begin
      data_d = data;
      rem_d  = {1'b0, amount};
      fill_d = (op == OP_SRA) && data[WIDTH-1];
      left_d = (op == OP_SLL);
    end else if (rem_q != '0) begin
      data_d = shifted;
      rem_d  = rem_q - step;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      rem_q  <= '0;
      fill_q <= 1'b0;
      left_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      fill_q <= fill_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with a one-deep result register and multi-cycle shifts.
// Define ALU_SEQ_MUL_EN to turn op 111 into a radix-2 unsigned multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero,
  output logic             out_equal,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic             busy
);

  localparam int SW = shamt_width(WIDTH);

  alu_state_e       state_q, state_d;
  alu_op_e          op;
  logic [SW-1:0]    shamt;
  logic             accept, is_shift, shift_start, mul_start, single_load;
  logic [WIDTH-1:0] sum, diff, z_now;
  logic             ovf_now, ill_now, eq_now, lt_now;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_z_q, out_z_d;
  logic             out_zero_q, out_zero_d;
  logic             out_equal_q, out_equal_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_ill_q, out_ill_d;
  logic             pend_eq_q, pend_eq_d;

  logic             sh_done;
  logic [WIDTH-1:0] sh_result;

  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    op       = alu_op_e'(in_op);
    shamt    = in_y[SW-1:0];
    is_shift = (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
    sum      = in_x + in_y;
    diff     = in_x - in_y;
    lt_now   = $signed(in_x) < $signed(in_y);
    z_now    = '0;
    ovf_now  = 1'b0;
    ill_now  = 1'b0;
    case (op)
      OP_AND: z_now = in_x & in_y;
      OP_ADD: begin
        z_now   = sum;
        ovf_now = (in_x[WIDTH-1] == in_y[WIDTH-1]) && (sum[WIDTH-1] != in_x[WIDTH-1]);
      end
      OP_SUB: begin
        z_now   = diff;
        ovf_now = (in_x[WIDTH-1] != in_y[WIDTH-1]) && (diff[WIDTH-1] != in_x[WIDTH-1]);
      end
      OP_SLT: z_now = {{(WIDTH-1){1'b0}}, lt_now};
      OP_SRL, OP_SRA, OP_SLL: z_now = in_x;  // zero-amount shifts pass x through
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: z_now = '0;
`else
      OP_MUL: ill_now = 1'b1;
`endif
      default: z_now = '0;
    endcase
    eq_now = (in_x == in_y) && !ill_now;
  end

  assign shift_start = accept && is_shift && (shamt != '0);
`ifdef ALU_SEQ_MUL_EN
  assign mul_start   = accept && (op == OP_MUL);
`else
  assign mul_start   = 1'b0;
`endif
  assign single_load = accept && !shift_start && !mul_start;

  alu_shift_unit #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (shift_start),
    .op     (op),
    .data   (in_x),
    .amount (shamt),
    .done   (sh_done),
    .result (sh_result)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int CNTW = SW + 1;

  logic [WIDTH-1:0] mul_hi_q, mul_hi_d, mul_lo_q, mul_lo_d, mul_x_q, mul_x_d;
  logic [CNTW-1:0]  mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0] mul_sum, mul_hi_n, mul_lo_n, mul_z;
  logic             mul_carry, mul_done, mul_ovf;

  // Right-shifting product register: {hi, lo} starts as {0, y} and ends as x*y.
  always_comb begin
    {mul_carry, mul_sum} = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mul_x_q} : '0);
    mul_hi_n  = {mul_carry, mul_sum[WIDTH-1:1]};
    mul_lo_n  = {mul_sum[0], mul_lo_q[WIDTH-1:1]};
    mul_done  = (state_q == ST_MUL) && (mul_cnt_q == CNTW'(1));
    mul_z     = mul_lo_n;
    mul_ovf   = (mul_hi_n != '0);
    mul_hi_d  = mul_hi_q;
    mul_lo_d  = mul_lo_q;
    mul_x_d   = mul_x_q;
    mul_cnt_d = mul_cnt_q;
    if (mul_start) begin
      mul_hi_d  = '0;
      mul_lo_d  = in_y;
      mul_x_d   = in_x;
      mul_cnt_d = CNTW'(WIDTH);
    end else if (state_q == ST_MUL) begin
      mul_hi_d  = mul_hi_n;
      mul_lo_d  = mul_lo_n;
      mul_cnt_d = mul_cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_hi_q  <= '0;
      mul_lo_q  <= '0;
      mul_x_q   <= '0;
      mul_cnt_q <= '0;
    end else begin
      mul_hi_q  <= mul_hi_d;
      mul_lo_q  <= mul_lo_d;
      mul_x_q   <= mul_x_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (shift_start) state_d = ST_SHIFT;
        else if (mul_start) state_d = ST_MUL;
      end
      ST_SHIFT: if (sh_done) state_d = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: if (mul_done) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: drains on out_ready, and a load on the same edge wins.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_z_d     = out_z_q;
    out_zero_d  = out_zero_q;
    out_equal_d = out_equal_q;
    out_ovf_d   = out_ovf_q;
    out_ill_d   = out_ill_q;
    pend_eq_d   = accept ? eq_now : pend_eq_q;
    if (single_load) begin
      out_valid_d = 1'b1;
      out_z_d     = z_now;
      out_zero_d  = (z_now == '0) && !ill_now;
      out_equal_d = eq_now;
      out_ovf_d   = ovf_now;
      out_ill_d   = ill_now;
    end else if ((state_q == ST_SHIFT) && sh_done) begin
      out_valid_d = 1'b1;
      out_z_d     = sh_result;
      out_zero_d  = (sh_result == '0);
      out_equal_d = pend_eq_q;
      out_ovf_d   = 1'b0;
      out_ill_d   = 1'b0;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_done) begin
      out_valid_d = 1'b1;
      out_z_d     = mul_z;
      out_zero_d  = (mul_z == '0);
      out_equal_d = pend_eq_q;
      out_ovf_d   = mul_ovf;
      out_ill_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_zero_q  <= 1'b0;
      out_equal_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_ill_q   <= 1'b0;
      pend_eq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_zero_q  <= out_zero_d;
      out_equal_q <= out_equal_d;
      out_ovf_q   <= out_ovf_d;
      out_ill_q   <= out_ill_d;
      pend_eq_q   <= pend_eq_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_z        = out_z_q;
  assign out_zero     = out_zero_q;
  assign out_equal    = out_equal_q;
  assign out_overflow = out_ovf_q;
  assign out_illegal  = out_ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32, SHIFT_STEP=4); honours ALU_SEQ_MUL_EN.
module tb_alu_seq;

  localparam int WIDTH      = 32;
  localparam int SHIFT_STEP = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'd0;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_z;
  logic             out_zero, out_equal, out_overflow, out_illegal, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_seq #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_x         (in_x),
    .in_y         (in_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_zero     (out_zero),
    .out_equal    (out_equal),
    .out_overflow (out_overflow),
    .out_illegal  (out_illegal),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation for exactly one cycle, then scramble the idle inputs.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    in_op    = op;
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    check("in_ready_at_offer", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_op    = 3'($urandom_range(0, 7));
    in_x     = $urandom;
    in_y     = $urandom;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_z, input logic exp_zero, input logic exp_eq,
                       input logic exp_ovf, input logic exp_ill, input int exp_lat);
    int n;
    issue(op, x, y);
    n = 1;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    $display("[TB] op=%0d x=%08h y=%08h -> z=%08h zero=%0b eq=%0b ovf=%0b ill=%0b lat=%0d",
             op, x, y, out_z, out_zero, out_equal, out_overflow, out_illegal, n);
    check("latency", 32'(n), 32'(exp_lat));
    check("z", out_z, exp_z);
    check("zero", 32'(out_zero), 32'(exp_zero));
    check("equal", 32'(out_equal), 32'(exp_eq));
    check("overflow", 32'(out_overflow), 32'(exp_ovf));
    check("illegal", 32'(out_illegal), 32'(exp_ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_z", out_z, 32'd0);
    check("rst_flags", 32'({out_zero, out_equal, out_overflow, out_illegal}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    $display("[TB] reset released");

    // Single-cycle arithmetic: op, x, y, z, zero, eq, ovf, ill, latency
    do_op(3'd1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0, 1);
    do_op(3'd2, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 1, 0, 0, 1);
    do_op(3'd2, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 0, 1, 0, 1);
    do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0, 0, 1);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 1, 0, 1);
    do_op(3'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1, 0, 0, 0, 1);
    do_op(3'd3, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 0, 1);
    do_op(3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 1);

    // Shifts: latency 1 + ceil(n/4); y=32 means amount 0
    do_op(3'd5, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 0, 0, 0, 0, 1);
    do_op(3'd5, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 0, 0, 0, 0, 2);
    do_op(3'd4, 32'h8000_0001, 32'h0000_0005, 32'h0400_0000, 0, 0, 0, 0, 3);
    do_op(3'd6, 32'h0000_0004, 32'h0000_0004, 32'h0000_0040, 0, 1, 0, 0, 2);
    do_op(3'd5, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1, 0, 0, 0, 9);

    // SRA by 9 cycle by cycle
    tick();
    issue(3'd5, 32'h8000_0000, 32'd9);
    check("sra_t1_busy", 32'(busy), 32'd1);
    check("sra_t1_in_ready", 32'(in_ready), 32'd0);
    check("sra_t1_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("sra_t2_busy", 32'(busy), 32'd1);
    tick();
    check("sra_t3_busy", 32'(busy), 32'd1);
    check("sra_t3_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("sra_t4_out_valid", 32'(out_valid), 32'd1);
    check("sra_t4_z", out_z, 32'hFFC0_0000);
    check("sra_t4_busy", 32'(busy), 32'd0);
    $display("[TB] sra x=80000000 by 9 -> z=%08h", out_z);
    tick();

    // Backpressure with a queued AND
    out_ready = 1'b0;
    issue(3'd3, 32'hFFFF_FFFF, 32'h0000_0001);
    in_op    = 3'd0;
    in_x     = 32'hF0F0_F0F0;
    in_y     = 32'hFF00_FF00;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_z", out_z, 32'd1);
      check("bp_flags", 32'({out_zero, out_equal, out_overflow, out_illegal}), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_refill_valid", 32'(out_valid), 32'd1);
    check("bp_refill_z", out_z, 32'hF000_F000);
    $display("[TB] backpressure slt held, queued and -> z=%08h", out_z);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of SLL by 31
    issue(3'd6, 32'h0000_0001, 32'd31);
    tick();
    tick();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    $display("[TB] reset during sll abandoned the operation");
    do_op(3'd1, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= out_valid;
    end
    check("no_stale_shift_result", 32'(seen), 32'd0);

    // Op 111
`ifdef ALU_SEQ_MUL_EN
    do_op(3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 1, 1, 0, 33);
    do_op(3'd7, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 0, 0, 1, 0, 33);
    do_op(3'd7, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0, 0, 0, 0, 33);
`else
    do_op(3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, 0, 0, 1, 1);
    do_op(3'd1, 32'h0000_0004, 32'h0000_0004, 32'h0000_0008, 0, 1, 0, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational 32-bit ALU.
- Keeps the same 3-bit op set (AND, ADD, SUB, SLT, SRL, SRA, SLL) and the zero/equal/overflow flags.
- Adds a configurable WIDTH, valid/ready handshakes on input and output, a one-deep registered result, and an iterative multi-cycle shifter.
- Sits between the decode/issue logic and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand and result width; must be ≥ 4 and a power of two.
- SHIFT_STEP, 4, maximum bit positions shifted per cycle; must be a power of two and ≤ WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts the operation this cycle
- in_op  in  3  000 AND, 001 ADD, 010 SUB, 011 SLT, 100 SRL, 101 SRA, 110 SLL, 111 reserved (MUL when enabled)
- in_x  in  WIDTH  operand x
- in_y  in  WIDTH  operand y; shift amount is y[log2(WIDTH)-1:0]
- out_valid  out  1  result held in the output register
- out_ready  in  1  consumer takes the result
- out_z  out  WIDTH  result
- out_zero  out  1  out_z == 0
- out_equal  out  1  x == y, on the accepted operands
- out_overflow  out  1  signed overflow (ADD/SUB only)
- out_illegal  out  1  op 111 executed with the multiply unit compiled out
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: while rst_n is low at a clock edge:
  - state → IDLE.
  - out_valid, out_z and all flags → 0.
  - busy → 0, and in_ready is forced to 0 during reset.
  - Any in-flight operation is abandoned with no output.
- Accept: transfer occurs when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready), so the output register can drain and refill in the same cycle.
- FSM states: IDLE, SHIFT, MUL (MUL only when the macro is defined).
- Single-cycle ops (AND/ADD/SUB/SLT, any shift with amount 0, reserved):
  - Accept at cycle T; out_valid = 1 with results at T+1.
  - FSM stays in IDLE.
- Shifts with amount n > 0:
  - IDLE → SHIFT at T+1.
  - Each SHIFT cycle shifts by min(remaining, SHIFT_STEP).
  - The result is written and out_valid rises at T+1+ceil(n/SHIFT_STEP), then SHIFT → IDLE.
  - SRA fills with x[WIDTH-1]; SRL and SLL fill with 0.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - overflow = (operand signs equal after y inversion for SUB) && (result sign differs); 0 for all other ops.
  - SLT is signed: z = {0…, x<y}.
- Flags:
  - equal is captured at accept.
  - zero is computed from the final z.
  - Reserved op: z = 0, zero = 0, equal = 0, overflow = 0, illegal = 1.
- Output hold: out_z and all flags stay stable while out_valid && !out_ready.
  - out_valid drops the cycle after out_ready unless a new result is written that same edge.
- Simultaneous drain and finish: a drain and a multicycle completion on the same edge loads the new result with no gap.
- in_x, in_y and in_op are ignored when no transfer occurs.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- When defined, op 111 is an unsigned multiply:
  - Radix-2 shift-add, one bit per cycle.
  - IDLE → MUL for WIDTH cycles; out_valid at T+1+WIDTH.
  - out_z = low WIDTH bits of the product.
  - out_overflow = (high WIDTH bits != 0).
  - out_zero and out_equal as for other ops; out_illegal = 0.
- When undefined, op 111 is reserved as described above, and no MUL state or multiplier logic exists.

Decomposition:
- Package alu_seq_pkg holds:
  - alu_op_e enum (3-bit, encodings above).
  - alu_state_e enum (IDLE, SHIFT, MUL).
  - Localparam helper for log2(WIDTH) shift-amount width.
- One sub-module: alu_shift_unit.
  - Holds the iterative shift register, remaining-count down-counter and fill bit.
  - Interface: start, op, data, amount → done, result.
- The top level keeps the FSM, handshakes, add/sub/slt/and datapath, flags and the optional multiplier.

Test Plan:
- ADD, x = 0x7FFFFFFF, y = 0x00000001, accept at T:
  - At T+1: z = 0x80000000, overflow = 1, zero = 0, equal = 0.
- SUB, x = y = 0x00000005:
  - At T+1: z = 0, zero = 1, equal = 1, overflow = 0.
- SRA, x = 0x80000000, y = 9, SHIFT_STEP = 4:
  - busy high T+1..T+3; in_ready low.
  - At T+4: z = 0xFFC00000.
- Backpressure: SLT with x = 0xFFFFFFFF, y = 1 → z = 1 at T+1.
  - Hold out_ready = 0 for 3 cycles: outputs stable, in_ready = 0.
  - Raise out_ready with a queued AND (x = 0xF0F0F0F0, y = 0xFF00FF00): back-to-back result 0xF000F000 the next cycle.
- Reset mid-operation: SLL by 31, assert rst_n = 0 at T+3:
  - Next cycle: out_valid = 0, busy = 0.
  - After release, ADD 2+3 yields z = 5 at T'+1.
- Op 111, x = 0x00010000, y = 0x00010000:
  - Without the macro: z = 0, illegal = 1 at T+1.
  - With ALU_SEQ_MUL_EN: z = 0, zero = 1, overflow = 1 at T+33.
